// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle PC/fetch controller for the RV32I core.
// Owns the program counter, fetches one instruction at a time over a req/ack
// handshake, holds it for execute, applies branch/jump redirects when execute
// retires the instruction, and counts retired instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        misalign_trap,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [31:0] target_jalr;

  // Next-state logic: fetch handshake, retire/redirect decision and the trap latch
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instret_d   = instret_q;
    trap_d      = trap_q;
    target_jalr = branch_target & 32'hFFFF_FFFE;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done && !stall) begin
          instret_d = instret_q + 32'd1;
          if (!branch_taken) begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end else if (target_jalr[1:0] == 2'b00) begin
            pc_d    = target_jalr;
            state_d = FETCH;
          end else begin
            trap_d  = 1'b1;
            state_d = TRAP;
          end
        end
      end
      TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  // Outputs are either register copies or a direct decode of the state register
  always_comb begin
    imem_req      = (state_q == FETCH);
    instr_valid   = (state_q == EXEC);
    imem_addr     = pc_q;
    pc            = pc_q;
    instr         = instr_q;
    instret       = instret_q;
    misalign_trap = trap_q;
  end

endmodule
